task_frame_in: RTL and testbench

- Parametrised successor to the task input stage. Requests one input frame over a valid/ready stream and stores it in an internal single-port-per-side RAM of DEPTH words.
- Replays the stored frame to the task core with a full valid/ready/last handshake and a reported frame length.
- Requests the next frame only after the first frame following reset, or after the downstream core signals completion (i_output_last).
- Adds features over the previous generation: backpressure on the output, frame-length reporting, and overflow detection.

---
 rtl/task_frame_in.sv | 190 +++++++++++++++++++
 tb/tb_task_frame_in.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/task_frame_in.sv
// Frame input stage: requests one frame over a valid/ready stream, buffers it
// in an inferred RAM, then replays it downstream with valid/ready/last and a
// reported length. A new frame is requested after reset or i_output_last.
module task_frame_in #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tvalid,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tlast,
  output logic                  o_tready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  input  logic                  i_output_last,
  output logic [LEN_WIDTH-1:0]  o_frame_len,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_WIDTH-1:0] DepthLen = LEN_WIDTH'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] OneLen   = LEN_WIDTH'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StPrime = 3'd3;
  localparam logic [2:0] StSend  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  req_pending_q, req_pending_d;
  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_hs;
  logic                  out_hs;
  logic                  wr_en;
  logic                  rd_en;
  logic [AddrWidth-1:0]  rd_addr;

  assign o_tready    = (state_q == StLoad);
  assign in_hs       = i_tvalid & o_tready;
  assign out_hs      = valid_q & i_ready;
  // Words beyond capacity are accepted but dropped so the sender never stalls.
  assign wr_en       = in_hs && (count_q < DepthLen);

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_last      = last_q;
  assign o_frame_len = frame_len_q;
  assign o_overflow  = overflow_q;
  assign o_busy      = (state_q != StIdle);

  // Next-state logic for the request/load/replay sequence.
  always_comb begin
    state_d       = state_q;
    req_pending_d = req_pending_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_len_d   = frame_len_q;
    overflow_d    = overflow_q;
    valid_d       = valid_q;
    last_d        = last_q;
    rd_en         = 1'b0;
    rd_addr       = rd_ptr_q;

    // A completion pulse outside IDLE is remembered until we get back there.
    if (i_output_last) begin
      req_pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // The pulse is consumed here directly so it is not acted on twice.
        if (req_pending_q || i_output_last) begin
          state_d       = StReq;
          req_pending_d = 1'b0;
        end
      end

      StReq: begin
        wr_ptr_d    = '0;
        count_d     = '0;
        overflow_d  = 1'b0;
        frame_len_d = '0;
        state_d     = StLoad;
      end

      StLoad: begin
        if (in_hs) begin
          if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          if (i_tlast) begin
            frame_len_d = wr_en ? (count_q + 1'b1) : DepthLen;
            state_d     = StPrime;
          end
        end
      end

      StPrime: begin
        // Word 0 lands in the output register as SEND begins.
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_ptr_d = AddrWidth'(1);
        valid_d  = 1'b1;
        last_d   = (frame_len_q == OneLen);
        state_d  = StSend;
      end

      StSend: begin
        if (out_hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StIdle;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_q;
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = (LEN_WIDTH'(rd_ptr_q) == (frame_len_q - OneLen));
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      req_pending_q <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_len_q   <= '0;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pending_q <= req_pending_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_len_q   <= frame_len_d;
      overflow_q    <= overflow_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
    end
  end

  // Frame buffer write port.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= i_tdata;
    end
  end

  // Frame buffer read port; holds the presented word while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_task_frame_in.sv
// Directed bench for task_frame_in with DEPTH=16.
module tb_task_frame_in;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned LW  = 5;

  logic          clk;
  logic          rst_n;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;
  logic          output_last;
  logic [LW-1:0] frame_len;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  task_frame_in #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEP),
    .LEN_WIDTH (LW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tvalid     (tvalid),
    .i_tdata      (tdata),
    .i_tlast      (tlast),
    .o_tready     (tready),
    .o_valid      (valid),
    .o_data       (data),
    .o_last       (last),
    .i_ready      (ready),
    .i_output_last(output_last),
    .o_frame_len  (frame_len),
    .o_overflow   (overflow),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed n words base..base+n-1 while in LOAD; tlast on the final one if with_last.
  task automatic send_frame(input int n, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      check_eq("tready_load", 32'(tready), 32'd1);
      tvalid = 1'b1;
      tdata  = base + DW'(i);
      tlast  = with_last && (i == n - 1);
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
  endtask

  // Expect n words base.. with o_last on the final one. bp selects ready
  // pattern 1,0,0,1,...; pulse_at drives i_output_last in that cycle.
  task automatic recv_frame(input int n, input logic [DW-1:0] base, input bit bp,
                            input int pulse_at);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < n && c < 200) begin
      check_eq("out_valid", 32'(valid), 32'd1);
      check_eq("out_data", 32'(data), 32'(base + DW'(k)));
      check_eq("out_last", 32'(last), 32'(k == n - 1));
      ready       = bp ? ((c % 3) == 0) : 1'b1;
      output_last = (c == pulse_at);
      tick();
      if (ready) k++;
      c++;
    end
    output_last = 1'b0;
    ready       = 1'b1;
    check_eq("recv_count", 32'(k), 32'(n));
    check_eq("valid_after_last", 32'(valid), 32'd0);
    check_eq("last_after_last", 32'(last), 32'd0);
  endtask

  // Pulse the completion input from IDLE and expect LOAD two cycles later.
  task automatic request_frame();
    output_last = 1'b1;
    tick();
    output_last = 1'b0;
    check_eq("req_tready_1", 32'(tready), 32'd0);
    tick();
    check_eq("req_tready_2", 32'(tready), 32'd1);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    tvalid      = 1'b0;
    tdata       = '0;
    tlast       = 1'b0;
    ready       = 1'b1;
    output_last = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_tready", 32'(tready), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_last", 32'(last), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_len", 32'(frame_len), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // First frame is requested automatically
    rst_n = 1'b1;
    tick();
    check_eq("first_req_tready_1", 32'(tready), 32'd0);
    check_eq("first_req_busy", 32'(busy), 32'd1);
    tick();
    check_eq("first_req_tready_2", 32'(tready), 32'd1);

    // Frame A: 5 words, no backpressure
    send_frame(5, 8'h10, 1'b1);
    check_eq("prime_valid", 32'(valid), 32'd0);
    check_eq("a_len", 32'(frame_len), 32'd5);
    tick();
    recv_frame(5, 8'h10, 1'b0, -1);
    check_eq("a_len_hold", 32'(frame_len), 32'd5);
    check_eq("a_ovf", 32'(overflow), 32'd0);
    check_eq("a_idle_busy", 32'(busy), 32'd0);

    // No completion pulse: no new request, stray tvalid ignored
    seen   = 0;
    tvalid = 1'b1;
    tdata  = 8'hEE;
    for (int i = 0; i < 50; i++) begin
      if (tready || busy) seen++;
      tick();
    end
    tvalid = 1'b0;
    tdata  = '0;
    check_eq("no_req_50", 32'(seen), 32'd0);

    // Frame B with output backpressure
    request_frame();
    send_frame(5, 8'h20, 1'b1);
    tick();
    recv_frame(5, 8'h20, 1'b1, -1);
    check_eq("b_len", 32'(frame_len), 32'd5);

    // Frame C: overflow, with an early completion pulse during SEND
    request_frame();
    send_frame(20, 8'h00, 1'b1);
    check_eq("c_len", 32'(frame_len), 32'd16);
    check_eq("c_ovf", 32'(overflow), 32'd1);
    tick();
    recv_frame(16, 8'h00, 1'b0, 3);
    check_eq("c_ovf_hold", 32'(overflow), 32'd1);
    check_eq("early_tready_0", 32'(tready), 32'd0);
    tick();
    check_eq("early_busy_req", 32'(busy), 32'd1);
    check_eq("early_tready_1", 32'(tready), 32'd0);
    tick();
    check_eq("early_tready_2", 32'(tready), 32'd1);
    check_eq("d_ovf_cleared", 32'(overflow), 32'd0);

    // Frame D: 3 words after overflow
    send_frame(3, 8'h30, 1'b1);
    check_eq("d_len", 32'(frame_len), 32'd3);
    check_eq("d_ovf", 32'(overflow), 32'd0);
    tick();
    recv_frame(3, 8'h30, 1'b0, -1);

    // Reset in the middle of loading
    request_frame();
    send_frame(3, 8'h40, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tready", 32'(tready), 32'd0);
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_data", 32'(data), 32'd0);
    check_eq("mid_rst_len", 32'(frame_len), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rerun_tready_1", 32'(tready), 32'd0);
    tick();
    check_eq("rerun_tready_2", 32'(tready), 32'd1);
    send_frame(4, 8'h50, 1'b1);
    check_eq("e_len", 32'(frame_len), 32'd4);
    tick();
    recv_frame(4, 8'h50, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
